// File: rtl/dict_loader.sv
// Fetches the packed dictionary image over imem and replays it into the three dictionary write ports.
// Optional trailer checksum is enabled with `define DICT_LOADER_CHECKSUM_EN.
module dict_loader #(
    parameter int          FIELD1_VAL_WIDTH = 7,
    parameter int          FIELD2_VAL_WIDTH = 10,
    parameter int          FIELD3_VAL_WIDTH = 15,
    parameter int          FIELD1_KEY_WIDTH = 3,
    parameter int          FIELD2_KEY_WIDTH = 5,
    parameter int          FIELD3_KEY_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR        = 32'h000F_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [31:0]                 mem_addr,
    input  logic [31:0]                 mem_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    localparam int K12  = (FIELD1_KEY_WIDTH > FIELD2_KEY_WIDTH) ?
                          FIELD1_KEY_WIDTH : FIELD2_KEY_WIDTH;
    localparam int KMAX = (K12 > FIELD3_KEY_WIDTH) ? K12 : FIELD3_KEY_WIDTH;
    localparam int N    = 1 << KMAX;
    localparam int IW   = KMAX + 1;
    localparam int D1   = 1 << FIELD1_KEY_WIDTH;
    localparam int D2   = 1 << FIELD2_KEY_WIDTH;
    localparam int D3   = 1 << FIELD3_KEY_WIDTH;
    localparam int F12  = FIELD1_VAL_WIDTH + FIELD2_VAL_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                      r_state;
    logic [IW-1:0]               r_idx;
    logic                        r_mem_valid;
    logic [31:0]                 r_mem_addr;
    logic                        r_we1;
    logic                        r_we2;
    logic                        r_we3;
    logic [FIELD1_VAL_WIDTH-1:0] r_val1;
    logic [FIELD2_VAL_WIDTH-1:0] r_val2;
    logic [FIELD3_VAL_WIDTH-1:0] r_val3;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_error;
`ifdef DICT_LOADER_CHECKSUM_EN
    logic [31:0]                 r_sum;
`endif

    logic          w_hs;
    logic          w_last;
    logic [IW-1:0] w_idx_nxt;
    logic          w_en1;
    logic          w_en2;
    logic          w_en3;

    assign w_hs      = r_mem_valid && mem_ready;
    assign w_last    = (r_idx == IW'(N - 1));
    assign w_idx_nxt = r_idx + IW'(1);
    assign w_en1     = (r_idx < IW'(D1));
    assign w_en2     = (r_idx < IW'(D2));
    assign w_en3     = (r_idx < IW'(D3));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_we1       <= 1'b0;
            r_we2       <= 1'b0;
            r_we3       <= 1'b0;
            r_val1      <= '0;
            r_val2      <= '0;
            r_val3      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef DICT_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_idx       <= '0;
                        r_mem_addr  <= BASE_ADDR;
                        r_mem_valid <= 1'b1;
                        r_busy      <= 1'b1;
`ifdef DICT_LOADER_CHECKSUM_EN
                        r_sum       <= '0;
`endif
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_hs) begin
                        r_mem_valid <= 1'b0;
                        r_we1       <= w_en1;
                        r_we2       <= w_en2;
                        r_we3       <= w_en3;
                        r_val1      <= mem_rdata[FIELD1_VAL_WIDTH-1:0];
                        r_val2      <= mem_rdata[F12-1:FIELD1_VAL_WIDTH];
                        r_val3      <= mem_rdata[31:F12];
`ifdef DICT_LOADER_CHECKSUM_EN
                        r_sum       <= r_sum + mem_rdata;
`endif
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_we1 <= 1'b0;
                    r_we2 <= 1'b0;
                    r_we3 <= 1'b0;
                    if (w_last) begin
`ifdef DICT_LOADER_CHECKSUM_EN
                        // Trailer word sits right after the last image word
                        r_mem_addr  <= BASE_ADDR + 32'(N * 4);
                        r_mem_valid <= 1'b1;
                        r_state     <= S_CHECK;
`else
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
`endif
                    end else begin
                        r_idx       <= w_idx_nxt;
                        r_mem_addr  <= BASE_ADDR + (32'(w_idx_nxt) << 2);
                        r_mem_valid <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
`ifdef DICT_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_hs) begin
                        r_mem_valid <= 1'b0;
                        r_error     <= (mem_rdata != r_sum);
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    // Level start: wait for it to drop before re-arming
                    if (!start) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_valid          = r_mem_valid;
    assign mem_addr           = r_mem_addr;
    assign dict1_write_enable = r_we1;
    assign dict1_write_val    = r_val1;
    assign dict2_write_enable = r_we2;
    assign dict2_write_val    = r_val2;
    assign dict3_write_enable = r_we3;
    assign dict3_write_val    = r_val3;
    assign busy               = r_busy;
    assign done               = r_done;
    assign error              = r_error;

endmodule

// File: tb/tb_dict_loader.sv
// Scoreboard bench for dict_loader: expected writes queued at load issue, popped by a monitor.
module tb_dict_loader;

    localparam logic [31:0] BASE = 32'h000F_0000;
    localparam int          N    = 256;
`ifdef DICT_LOADER_CHECKSUM_EN
    localparam bit          CK   = 1'b1;
`else
    localparam bit          CK   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        dict1_write_enable;
    logic [6:0]  dict1_write_val;
    logic        dict2_write_enable;
    logic [9:0]  dict2_write_val;
    logic        dict3_write_enable;
    logic [14:0] dict3_write_val;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    dict_loader dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .mem_valid          (mem_valid),
        .mem_ready          (mem_ready),
        .mem_addr           (mem_addr),
        .mem_rdata          (mem_rdata),
        .dict1_write_enable (dict1_write_enable),
        .dict1_write_val    (dict1_write_val),
        .dict2_write_enable (dict2_write_enable),
        .dict2_write_val    (dict2_write_val),
        .dict3_write_enable (dict3_write_enable),
        .dict3_write_val    (dict3_write_val),
        .busy               (busy),
        .done               (done),
        .error              (error)
    );

    int chk = 0;
    int err = 0;
    int lat = 1;
    bit flip = 1'b0;
    int wc1 = 0;
    int wc2 = 0;
    int wc3 = 0;
    int nwr = 0;
    logic [6:0]  q1[$];
    logic [9:0]  q2[$];
    logic [14:0] q3[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(int i);
        return {15'(i), 10'(i), 7'(i)};
    endfunction

    function automatic logic [31:0] img(int i);
        logic [31:0] s;
        if (i < N) return word(i);
        s = '0;
        for (int k = 0; k < N; k++) s += word(k);
        return s ^ {31'b0, flip};
    endfunction

    // Memory model: ready comes lat cycles after valid rises
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_valid && !mem_ready) begin
                cnt++;
                if (cnt > lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = img(int'((mem_addr - BASE) >> 2));
                    cnt = 0;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom();
                cnt = 0;
            end
        end
    end

    // Monitor: checks write cycle after each handshake, stability during stalls
    initial begin
        logic        pend;
        logic [31:0] paddr;
        logic        pv;
        logic        pr;
        int          idx;
        pend = 1'b0;
        pv = 1'b0;
        pr = 1'b0;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
                pv = 1'b0;
            end else begin
                if (pend) begin
                    idx = int'((paddr - BASE) >> 2);
                    check("d1_en", dict1_write_enable, idx < 8);
                    check("d2_en", dict2_write_enable, idx < 32);
                    check("d3_en", dict3_write_enable, idx < 256);
                    if (idx < N) nwr++;
                    if (dict1_write_enable) begin
                        wc1++;
                        if (q1.size() == 0) begin
                            chk++; err++;
                            $display("FAIL d1_extra actual=%0h expected=none", dict1_write_val);
                        end else check("d1_val", dict1_write_val, q1.pop_front());
                    end
                    if (dict2_write_enable) begin
                        wc2++;
                        if (q2.size() == 0) begin
                            chk++; err++;
                            $display("FAIL d2_extra actual=%0h expected=none", dict2_write_val);
                        end else check("d2_val", dict2_write_val, q2.pop_front());
                    end
                    if (dict3_write_enable) begin
                        wc3++;
                        if (q3.size() == 0) begin
                            chk++; err++;
                            $display("FAIL d3_extra actual=%0h expected=none", dict3_write_val);
                        end else check("d3_val", dict3_write_val, q3.pop_front());
                    end
                end else begin
                    check("stray_we",
                          {dict1_write_enable, dict2_write_enable, dict3_write_enable}, 0);
                end
                if (pv && !pr) begin
                    check("stall_valid", mem_valid, 1);
                    check("stall_addr", mem_addr, paddr);
                end
                pend = mem_valid && mem_ready;
                paddr = mem_addr;
                pv = mem_valid;
                pr = mem_ready;
            end
        end
    end

    task automatic push_exp();
        for (int i = 0; i < N; i++) begin
            if (i < 8) q1.push_back(7'(i));
            if (i < 32) q2.push_back(10'(i));
            q3.push_back(15'(i));
        end
    endtask

    task automatic check_reset_vals();
        check("rst_valid", mem_valid, 0);
        check("rst_addr", mem_addr, BASE);
        check("rst_we", {dict1_write_enable, dict2_write_enable, dict3_write_enable}, 0);
        check("rst_vals", {dict1_write_val, dict2_write_val, dict3_write_val}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
    endtask

    task automatic wait_done(string name, int maxc);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, done, 1);
    endtask

    task automatic check_end(string tag, int s1, int s2, int s3);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_n1"}, wc1 - s1, 8);
        check({tag, "_n2"}, wc2 - s2, 32);
        check({tag, "_n3"}, wc3 - s3, 256);
        check({tag, "_qempty"}, q1.size() + q2.size() + q3.size(), 0);
        check({tag, "_error"}, error, CK ? flip : 1'b0);
    endtask

    task automatic run_load(string tag);
        int s1, s2, s3;
        s1 = wc1; s2 = wc2; s3 = wc3;
        push_exp();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_first_valid"}, mem_valid, 1);
        check({tag, "_first_addr"}, mem_addr, BASE);
        check({tag, "_busy_on"}, busy, 1);
        check({tag, "_done_clr"}, done, 0);
        wait_done({tag, "_done"}, 4000);
        check_end(tag, s1, s2, s3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int s1, s2, s3, sw, n;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        lat = 1;
        run_load("full");

        lat = 5;
        run_load("stall");
        lat = 1;

        // Reset while fetching idx 100
        push_exp();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(mem_valid && mem_addr == BASE + 32'd400) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx100", mem_addr, BASE + 32'd400);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        #1;
        q1.delete();
        q2.delete();
        q3.delete();
        reset = 1'b0;
        run_load("after_rst");

        // Level start held long: exactly one load
        s1 = wc1; s2 = wc2; s3 = wc3; sw = nwr;
        push_exp();
        @(negedge clk);
        start = 1'b1;
        repeat (2000) @(negedge clk);
        check("held_writes", nwr - sw, 256);
        check("held_done", done, 1);
        check_end("held", s1, s2, s3);
        start = 1'b0;
        @(negedge clk);
        check("held_done_sticky", done, 1);
        s1 = wc1; s2 = wc2; s3 = wc3;
        push_exp();
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("reload_done_low", done, 0);
        check("reload_busy", busy, 1);
        wait_done("reload_done", 4000);
        check_end("reload", s1, s2, s3);
        start = 1'b0;

        if (CK) begin
            flip = 1'b1;
            run_load("bad_sum");
            flip = 1'b0;
            run_load("good_sum");
        end

        repeat (3) @(negedge clk);
        check("final_done", done, 1);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
